// File: rtl/multi_sync_debounce.sv
// Multi-channel synchronizer and debouncer with per-channel edge pulses.
// Define SYNC_DEBOUNCE_EN to enable the debounce counters; without it the level follows sync directly.
module multi_sync_debounce #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] out_rise,
  output logic [WIDTH-1:0] out_fall,
  output logic             any_change
);

  logic [STAGES-1:0] chain [WIDTH];
  logic [WIDTH-1:0]  sync;
  logic [WIDTH-1:0]  accept;

  // The last flop of each chain is the only one safe to use downstream.
  always_comb begin
    sync = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sync[i] = chain[i][STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        chain[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        chain[i] <= {chain[i][STAGES-2:0], in_async[i]};
      end
    end
  end

`ifdef SYNC_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt      [WIDTH];
  logic [CW-1:0] cnt_next [WIDTH];

  // A channel is accepted on the edge where its mismatch has lasted DB_CYCLES clocks.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (sync[i] == out_level[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == LAST) begin
        accept[i]   = 1'b1;
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end
`else
  assign accept = sync ^ out_level;
`endif

  // Pulses are registered on the same edge as the level so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_level  <= '0;
      out_rise   <= '0;
      out_fall   <= '0;
      any_change <= 1'b0;
    end else begin
      out_level  <= out_level ^ accept;
      out_rise   <= accept & sync;
      out_fall   <= accept & ~sync;
      any_change <= |accept;
    end
  end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Self-checking bench for multi_sync_debounce: directed scenarios plus random toggling,
// checked every clock against a sliding-window reference model.
module tb_multi_sync_debounce;

  localparam int WIDTH     = 4;
  localparam int STAGES    = 2;
  localparam int DB_CYCLES = 4;
`ifdef SYNC_DEBOUNCE_EN
  localparam int MDB = DB_CYCLES;
`else
  localparam int MDB = 1;
`endif
  localparam int LAT = STAGES + MDB;
  localparam int HN  = STAGES + MDB;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_async = '0;
  logic [WIDTH-1:0] out_level, out_rise, out_fall;
  logic             any_change;

  int nvec = 0;
  int nerr = 0;

  logic [WIDTH-1:0] hist [HN];
  logic [WIDTH-1:0] m_level = '0;
  logic [WIDTH-1:0] m_rise  = '0;
  logic [WIDTH-1:0] m_fall  = '0;

  multi_sync_debounce #(.WIDTH(WIDTH), .STAGES(STAGES), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .rst(rst), .in_async(in_async),
    .out_level(out_level), .out_rise(out_rise), .out_fall(out_fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < HN; k++) hist[k] = '0;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic check_all();
    chk("level", out_level, m_level);
    chk("rise", out_rise, m_rise);
    chk("fall", out_fall, m_fall);
    chk("any_change", {{(WIDTH-1){1'b0}}, any_change}, {{(WIDTH-1){1'b0}}, |(m_rise | m_fall)});
    chk("rise_fall_excl", out_rise & out_fall, '0);
  endtask

  // Level flips when the last MDB samples reaching the output side all disagree with it.
  task automatic step(input logic [WIDTH-1:0] v);
    logic all_one, all_zero;
    in_async = v;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v;
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < WIDTH; ch++) begin
        all_one  = 1'b1;
        all_zero = 1'b1;
        for (int k = STAGES; k < STAGES + MDB; k++) begin
          if (hist[k][ch]) all_zero = 1'b0;
          else             all_one  = 1'b0;
        end
        if (!m_level[ch] && all_one) begin
          m_level[ch] = 1'b1;
          m_rise[ch]  = 1'b1;
        end else if (m_level[ch] && all_zero) begin
          m_level[ch] = 1'b0;
          m_fall[ch]  = 1'b1;
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    model_clear();

    // Reset held with all inputs high: everything stays 0.
    rst = 1'b0;
    for (int e = 0; e < 10; e++) step(4'hF);
    rst = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'hF);
      if (e == LAT - 1) chk("rel_level_early", out_level, 4'h0);
      if (e == LAT)     chk("rel_rise", out_rise, 4'hF);
      if (e == LAT + 1) chk("rel_rise_gone", out_rise, 4'h0);
    end

    // Settle all low, then a single-channel rise and fall on ch0.
    for (int e = 0; e < LAT + 2; e++) step(4'h0);
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'h1);
      if (e == LAT) chk("ch0_rise", out_rise, 4'h1);
    end
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'h0);
      if (e == LAT) chk("ch0_fall", out_fall, 4'h1);
    end

    // Short glitches on ch1 and ch0.
    for (int e = 0; e < 3; e++) step(4'h2);
    for (int e = 0; e < LAT + 3; e++) step(4'h0);
    step(4'h1);
    for (int e = 0; e < LAT + 3; e++) step(4'h0);

    // ch3 settled high, then ch2 rises while ch3 falls on the same edge.
    for (int e = 0; e < LAT + 2; e++) step(4'h8);
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'h4);
      if (e == LAT) begin
        chk("simul_rise", out_rise, 4'h4);
        chk("simul_fall", out_fall, 4'h8);
      end
    end
    for (int e = 0; e < LAT + 2; e++) step(4'h0);

    // Reset two edges into a ch0 qualification clears outputs at once.
    step(4'h1);
    step(4'h1);
    rst = 1'b0;
    #1;
    chk("async_rst_level", out_level, 4'h0);
    model_clear();
    step(4'h1);
    step(4'h1);
    rst = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'h1);
      if (e == LAT - 1) chk("rst_requal_early", out_level, 4'h0);
      if (e == LAT)     chk("rst_requal_rise", out_rise, 4'h1);
    end

    // Random toggling with varied hold lengths.
    v = in_async;
    for (int n = 0; n < 400; n++) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        if ($urandom_range(0, 3) == 0) v[ch] = ~v[ch];
      end
      step(v);
    end
    for (int e = 0; e < LAT + 2; e++) step(v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multi_sync_debounce.md
MULTI_SYNC_DEBOUNCE -- requirements
Module: multi_sync_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels, minimum 1.
REQ-002 Parameter STAGES, default 2: synchronizer flop stages per channel, minimum 2.
REQ-003 Parameter DB_CYCLES, default 16: consecutive stable clocks required to accept a new level, minimum 1.
REQ-004 clk  input  1  synchronous clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_async  input  WIDTH  asynchronous channel inputs (buttons/switches), no timing relation to clk.
REQ-007 out_level  output  WIDTH  synchronized, debounced level per channel.
REQ-008 out_rise  output  WIDTH  one-clock pulse per channel on accepted 0->1 transition.
REQ-009 out_fall  output  WIDTH  one-clock pulse per channel on accepted 1->0 transition.
REQ-010 any_change  output  1  OR-reduction of out_rise | out_fall, registered identically (same cycle as the pulses).

Function
REQ-011 Each channel SHALL pass in_async[i] through a chain of STAGES flops; sync[i] is the last stage output.
REQ-012 Each channel SHALL own a counter of width $clog2(DB_CYCLES+1) bits.
REQ-013 If sync[i] == out_level[i], counter SHALL clear to 0 on that edge.
REQ-014 If sync[i] != out_level[i] and counter < DB_CYCLES-1, counter SHALL increment by 1.
REQ-015 If sync[i] != out_level[i] and counter == DB_CYCLES-1, out_level[i] SHALL take sync[i] and counter SHALL clear on that edge.
REQ-016 Net latency: an input held stable produces out_level change exactly STAGES+DB_CYCLES rising edges after it is first sampled.
REQ-017 A sync-level disturbance lasting fewer than DB_CYCLES clocks SHALL produce no out_level change and no pulse.
REQ-018 out_rise[i] SHALL be 1 for exactly the one cycle in which out_level[i] first reads 1 after reading 0; out_fall[i] symmetric; both 0 otherwise.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 out_rise[i] and out_fall[i] SHALL never be 1 in the same cycle.

Reset
REQ-021 While rst=0: all sync flops, counters, out_level, out_rise, out_fall, any_change SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-count SHALL discard the count; after release, qualification restarts from 0.
REQ-023 A channel input already 1 at reset release SHALL yield a normal out_rise pulse after STAGES+DB_CYCLES edges.

Configuration
REQ-024 Macro SYNC_DEBOUNCE_EN defined: debounce counters per REQ-012..REQ-017 SHALL be implemented.
REQ-025 SYNC_DEBOUNCE_EN undefined: no counters; out_level SHALL equal sync registered once (latency STAGES+1); DB_CYCLES ignored; edge pulses per REQ-018 unchanged.

Verification (WIDTH=4, STAGES=2, DB_CYCLES=4 unless noted)
REQ-026 rst=0, in_async=4'hF for 10 clocks -> all outputs 0 throughout; release rst -> out_level=4'hF and out_rise=4'hF exactly 6 edges later, for 1 cycle; any_change=1 that cycle.
REQ-027 in_async[0] 0->1 held -> out_level[0]=1 after 6 edges, out_rise[0] one cycle, other channels unchanged; later 1->0 -> out_fall[0] one cycle after 6 edges.
REQ-028 in_async[1] high for 3 clocks then low -> out_level[1] stays 0, no pulse, counter back to 0.
REQ-029 in_async[2] 0->1 and in_async[3] 1->0 on the same edge (ch3 previously settled high) -> out_rise[2] and out_fall[3] in the same cycle.
REQ-030 rst pulsed low 2 edges into a ch0 qualification -> outputs clear immediately; ch0 accepted 6 edges after release, not earlier.
REQ-031 SYNC_DEBOUNCE_EN undefined: 1-clock high glitch on in_async[0] -> out_level[0] high for 1 cycle at edge 3, out_rise[0] then out_fall[0] on consecutive cycles.
